// File: rtl/trig_burst_framer.sv
// trig_burst_framer: cuts the gated {I16,Q16} sample stream into fixed-length
// frames (header + burst_len samples) and queues them in a 34-bit FWFT FIFO.
// A FIFO overflow mid-frame closes the frame with a 0xDEAD terminator so
// downstream framing stays aligned.
module trig_burst_framer #(
    parameter logic [7:0]  BASE        = 8'd0,
    parameter int unsigned FIFO_AWIDTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] in_sample,
    input  logic        in_strobe,
    output logic [31:0] out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic [15:0] frame_seq
);

    localparam int unsigned Depth = 1 << FIFO_AWIDTH;
    localparam logic [FIFO_AWIDTH:0] DepthW = (FIFO_AWIDTH + 1)'(Depth);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StPend = 2'd1;
    localparam logic [1:0] StBody = 2'd2;
    localparam logic [1:0] StTerm = 2'd3;

    // Settings register
    logic [15:0] burst_len_q;
    logic [15:0] eff_len;
    logic        unused_set_data;

    // Framer state
    logic [1:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic [15:0] seq_q, seq_d;
    logic [31:0] pend_q, pend_d;
    logic        ovf_q, ovf_d;

    // FIFO
    logic [33:0]          mem [Depth];
    logic [FIFO_AWIDTH:0] wr_ptr_q, rd_ptr_q;
    logic [33:0]          head;
    logic                 empty, full, pop, can_push, push, flush;
    logic [33:0]          push_word;

    assign unused_set_data = ^set_data[31:16];
    // A programmed length of 0 would never close a frame, so it acts as 1.
    assign eff_len = (burst_len_q == 16'd0) ? 16'd1 : burst_len_q;
    assign cnt_inc = cnt_q + 16'd1;

    assign flush    = clear | ~enable;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = ((wr_ptr_q - rd_ptr_q) == DepthW);
    assign pop      = ~empty & out_ready;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign can_push = ~full | pop;

    assign head      = mem[rd_ptr_q[FIFO_AWIDTH-1:0]];
    assign out_valid = ~empty;
    assign out_data  = out_valid ? head[31:0] : 32'd0;
    assign out_sof   = out_valid & head[33];
    assign out_eof   = out_valid & head[32];
    assign overflow  = ovf_q;
    assign frame_seq = seq_q;

    // Control register write; burst_len is only sampled at header time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            burst_len_q <= 16'd256;
        end else if (set_stb && (set_addr == BASE)) begin
            burst_len_q <= set_data[15:0];
        end
    end

    // Framer next-state: decides which word (if any) enters the FIFO this cycle.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        pend_d    = pend_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        push_word = 34'd0;
        unique case (state_q)
            StIdle: begin
                if (in_strobe) begin
                    if (can_push) begin
                        push      = 1'b1;
                        push_word = {1'b1, 1'b0, seq_q, eff_len};
                        len_d     = eff_len;
                        seq_d     = seq_q + 16'd1;
                        pend_d    = in_sample;
                        cnt_d     = 16'd0;
                        state_d   = StPend;
                    end else begin
                        // Header lost: drop the sample, no frame was opened.
                        ovf_d = 1'b1;
                    end
                end
            end
            StPend: begin
                if (in_strobe) begin
                    ovf_d = 1'b1;
                end
                if (can_push) begin
                    push      = 1'b1;
                    push_word = {1'b0, (len_q == 16'd1), pend_q};
                    cnt_d     = 16'd1;
                    state_d   = (len_q == 16'd1) ? StIdle : StBody;
                end else begin
                    ovf_d   = 1'b1;
                    state_d = StTerm;
                end
            end
            StBody: begin
                if (in_strobe) begin
                    if (can_push) begin
                        push      = 1'b1;
                        push_word = {1'b0, (cnt_inc == len_q), in_sample};
                        cnt_d     = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = StIdle;
                        end
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = StTerm;
                    end
                end
            end
            StTerm: begin
                // Samples arriving here are discarded until the terminator fits.
                if (can_push) begin
                    push      = 1'b1;
                    push_word = {1'b0, 1'b1, 16'hDEAD, cnt_q};
                    state_d   = StIdle;
                end
            end
        endcase
        if (flush) begin
            state_d = StIdle;
            seq_d   = 16'd0;
            cnt_d   = 16'd0;
            push    = 1'b0;
            if (clear) begin
                ovf_d = 1'b0;
            end
        end
    end

    // Framer state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            len_q   <= 16'd1;
            cnt_q   <= 16'd0;
            seq_q   <= 16'd0;
            pend_q  <= 32'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO pointers; flush empties the queue without touching storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // FIFO storage: {sof, eof, data}
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q[FIFO_AWIDTH-1:0]] <= push_word;
        end
    end

endmodule

// File: doc/trig_burst_framer.md
# trig_burst_framer

Downstream stage of the RX power trigger. It consumes the gated baseband sample stream ({I16,Q16} plus strobe) and cuts it into fixed-length frames. Each frame gets a header word, and frames are buffered in a small first-word-fall-through FIFO that drives a valid/ready output toward the VITA/packet path. If the FIFO overflows, the frame ends with a terminator word, so downstream framing always stays aligned.

## Interface
Parameters:
- BASE, 0, settings-bus address of the control register
- FIFO_AWIDTH, 4, log2 of FIFO depth (16 entries of 34 bits)

Ports:
- clock  in  1  DSP clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush on packet-control init
- enable  in  1  streaming enable; low acts as synchronous flush
- set_stb  in  1  settings strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- in_sample  in  32  {I16,Q16} sample from the power trigger
- in_strobe  in  1  sample valid
- out_data  out  32  header, sample or terminator word
- out_sof  out  1  first word of frame (header)
- out_eof  out  1  last word of frame
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accepts word
- overflow  out  1  sticky: a sample was dropped
- frame_seq  out  16  sequence number of the next header

## Operation
- Register BASE+0, bits [15:0] = burst_len, reset value 256. A value of 0 is treated as 1. The value is latched at each header, so a write mid-frame takes effect from the next frame.
- Header word = {frame_seq[15:0], latched_len[15:0]}, with sof=1. frame_seq increments after each header and wraps 0xFFFF->0.
- Terminator word = {16'hDEAD, delivered_count[15:0]}, with eof=1.
- FSM states:
  - IDLE: on in_strobe, push the header, capture in_sample into a pending register, go to PEND.
  - PEND (one cycle): push the pending sample with cnt=1. If latched_len==1, set eof and go to IDLE; otherwise go to BODY.
  - BODY: on in_strobe, push the sample and increment cnt. On the sample where cnt reaches latched_len, set eof and go to IDLE.
  - TERM: wait until the FIFO is not full, push the terminator, go to IDLE.
- Overflow handling: any required push while the FIFO is full drops that word, sets overflow and goes to TERM. While in TERM, incoming samples are discarded.
- If the header itself cannot be pushed, the sample is dropped, overflow is set and the state stays IDLE. No terminator is pushed in this case.
- Input rule: in_strobe is never high on two consecutive cycles. If in_strobe is high in PEND, that sample is dropped and overflow is set, but the frame continues.
- clear=1 or enable=0 (synchronous): FIFO emptied, FSM to IDLE, frame_seq=0, cnt=0. clear also clears overflow; enable=0 does not.
- A simultaneous push and pop when the FIFO is full is allowed: the pop frees the slot in the same cycle.

## Timing
- Reset values:
  - out_valid=0, out_sof=0, out_eof=0, out_data=0, overflow=0, frame_seq=0
  - burst_len=256, FSM=IDLE
- out_data, out_sof and out_eof are forced to 0 whenever out_valid=0.
- Latency: for an in_strobe at cycle N in IDLE with an empty FIFO, the header is visible at N+1 and the first sample at N+2, provided the header was popped at N+1.
- In BODY, a strobe at cycle N makes the sample available at N+1, behind any queued words.
- Handshake: a word transfers when out_valid & out_ready. out_valid never deasserts without a transfer, except on clear, enable low or reset.
- Asynchronous reset mid-frame discards the FIFO contents. No terminator is emitted.

## Test plan
- burst_len=4, out_ready=1, strobes every 4 cycles with samples 1..8. Output: hdr 0x0000_0004(sof), 1, 2, 3, 4(eof), hdr 0x0001_0004(sof), 5, 6, 7, 8(eof).
- burst_len=1, three strobes. Output: three two-word frames with seq 0, 1, 2. Every sample word has eof=1.
- burst_len=64, out_ready=0, strobes every 2 cycles. The FIFO fills at 16 words (header + 15 samples), overflow goes to 1. Then raise out_ready: 16 words drain, then 0xDEAD_000F(eof), and the next strobe starts a header with seq 1.
- Mid-frame write of burst_len 8->3 during an 8-sample frame. The current frame still carries 8 samples; the next header reads len=3.
- Pulse clear mid-frame with words queued. out_valid is 0 the next cycle, overflow=0, and the next header shows seq 0.
- Assert reset asynchronously between clock edges while in BODY. Outputs go to their reset values immediately, and burst_len reads back 256.
